mulseq: RTL and testbench
=========================

# mulseq

Multi-cycle shift-add multiplier: the counterpart to the team's sequential divider. It uses the same go/done handshake, so datapath controllers drive both with the same sequencing logic. One operation returns a double-width product. It trades latency (one cycle per operand bit) for a single adder and a high clock rate. A SIGNED parameter selects the sign-magnitude operand format the signed divider uses.

## Interface
- DATAWIDTH, 32: operand width in bits; legal range 4..64.
- SIGNED, 0: 0 = unsigned operands; 1 = sign-magnitude operands (bit DATAWIDTH-1 is the sign, the lower DATAWIDTH-1 bits are the magnitude).
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- go  in  1  start request; sampled on the rising edge of clk.
- a  in  DATAWIDTH  multiplicand; captured at start.
- b  in  DATAWIDTH  multiplier; captured at start.
- p  out  2*DATAWIDTH  product; valid while done=1.
- done  out  1  high once the product is ready; stays high until the next start.

## Operation
- Control state is the register running. Define start = go && !running.
- Idle (running=0):
  - start loads the operand registers and clears the accumulator and the iteration counter.
  - The same edge sets running=1 and clears done.
- Run (running=1):
  - Each edge performs one iteration on the accumulator {c, hi, lo}, where c is 1 bit and hi/lo are DATAWIDTH bits each; lo is loaded with the multiplier magnitude.
  - If lo[0]=1, {c, hi} = hi + multiplicand magnitude.
  - Then {c, hi, lo} is shifted right by one, with 0 entering at the top.
  - go is ignored while running; changes on a and b during a run have no effect.
- Iteration count N = DATAWIDTH for SIGNED=0, and DATAWIDTH-1 for SIGNED=1.
- Completion: the edge that performs iteration N also sets done=1 and running=0.
- Unsigned output: p = {hi, lo}, the full 2*DATAWIDTH-bit unsigned product.
- Signed output:
  - Magnitudes are the lower DATAWIDTH-1 bits of a and b; their product fits in 2*DATAWIDTH-2 bits.
  - p[2*DATAWIDTH-1] = a[DATAWIDTH-1] ^ b[DATAWIDTH-1], using the captured sign bits.
  - p[2*DATAWIDTH-2] = 0.
  - p[2*DATAWIDTH-3:0] = magnitude product.
  - A zero magnitude with differing signs gives negative zero; this is not normalised, matching the divider.
- p and done hold their values until the next start or reset.

## Timing
- Reset values: running=0, done=0, p=0, and the iteration counter is 0. The operand registers need no reset.
- The start edge is E0. Iterations occur on edges E1..EN, and done rises at EN. Latency from start edge to done is N cycles: 32 unsigned or 31 signed at the default width.
- p is stable and correct from EN onward. p is not required to hold a meaningful value between E0 and EN; the bench checks p only while done=1.
- Back-to-back operation:
  - With go held high, running=0 after EN, so the next start occurs at EN+1.
  - Issue period is N+1 cycles; done is high for exactly one cycle, and its falling edge coincides with the new start.
- go=1 on the same edge that sets done is not a start, because running is still 1 when it is sampled.
- Reset asserted mid-run aborts immediately:
  - done=0 and running=0 with no clock needed.
  - After release, the first go starts a fresh operation with full latency N.
- No combinational path exists from go, a or b to p or done; both outputs are registered.

## Test plan
- Unsigned W=32: a=3, b=5, 1-cycle go pulse -> done rises exactly 32 edges after the start edge; p=0x0000_0000_0000_000F; done and p hold while go=0.
- Unsigned extremes: a=b=0xFFFF_FFFF -> p=0xFFFF_FFFE_0000_0001.
  - a=0, b=0xFFFF_FFFF -> p=0.
  - a=1, b=0x8000_0000 -> p=0x0000_0000_8000_0000.
- Signed W=32: a=0x8000_0003 (-3), b=0x0000_0005 -> done after 31 cycles; p=0x8000_0000_0000_000F.
  - a=0x8000_0007, b=0x8000_0002 -> p=0x0000_0000_0000_000E.
- Operand isolation: start with a=6, b=7, then change a and b and pulse go every cycle during the run -> no restart; done at E32; p=42.
- Back-to-back: go held high with operand pairs (2,3) then (4,5) -> done pulses one cycle at E32 and at E65; p=6, then p=20.
- Reset mid-run: assert reset asynchronously at E10 -> done and running drop immediately. Release, start a=9, b=9 -> done 32 cycles later; p=81.

Source files
------------

// File: rtl/mulseq.sv
// rtl/mulseq.sv - multi-cycle shift-add multiplier with go/done handshake
// One accumulator add per cycle; SIGNED=1 treats operands as sign-magnitude.
module mulseq #(
  parameter int DATAWIDTH = 32,
  parameter int SIGNED    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [DATAWIDTH-1:0]     a,
  input  logic [DATAWIDTH-1:0]     b,
  output logic [2*DATAWIDTH-1:0]   p,
  output logic                     done
);

  localparam int N_ITER = (SIGNED != 0) ? DATAWIDTH - 1 : DATAWIDTH;
  localparam int CW     = $clog2(DATAWIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   start;
  logic                   last;
  logic [CW-1:0]          count;
  logic [DATAWIDTH-1:0]   mcand;
  logic [DATAWIDTH-1:0]   hi;
  logic [DATAWIDTH-1:0]   lo;
  logic [DATAWIDTH-1:0]   a_mag;
  logic [DATAWIDTH-1:0]   b_mag;
  logic [DATAWIDTH:0]     sum;
  logic                   done_q;

  // Operand magnitudes: sign bits are stripped in sign-magnitude mode
  generate
    if (SIGNED != 0) begin : g_mag_signed
      assign a_mag = {1'b0, a[DATAWIDTH-2:0]};
      assign b_mag = {1'b0, b[DATAWIDTH-2:0]};
    end else begin : g_mag_unsigned
      assign a_mag = a;
      assign b_mag = b;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          start      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (count == CW'(N_ITER - 1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Carry out of the add lands in the top bit and is shifted straight into hi
  always_comb begin
    sum = {1'b0, hi};
    if (lo[0]) begin
      sum = {1'b0, hi} + {1'b0, mcand};
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mcand <= a_mag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      hi     <= '0;
      lo     <= b_mag;
      count  <= '0;
      done_q <= 1'b0;
    end else if (state == RUN) begin
      hi    <= sum[DATAWIDTH:1];
      lo    <= {sum[0], lo[DATAWIDTH-1:1]};
      count <= count + 1'b1;
      if (last) begin
        done_q <= 1'b1;
      end
    end
  end

  assign done = done_q;

  // After DATAWIDTH-1 shifts the magnitude product sits one bit above lo[0]
  generate
    if (SIGNED != 0) begin : g_out_signed
      logic sign_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sign_q <= 1'b0;
        end else if (start) begin
          sign_q <= a[DATAWIDTH-1] ^ b[DATAWIDTH-1];
        end
      end

      assign p = {sign_q, 1'b0, hi[DATAWIDTH-2:0], lo[DATAWIDTH-1:1]};
    end else begin : g_out_unsigned
      assign p = {hi, lo};
    end
  endgenerate

endmodule

// File: tb/tb_mulseq.sv
// tb/tb_mulseq.sv - self-checking bench for mulseq, unsigned and signed instances
// Random operands are checked against a plain-arithmetic product model.
module tb_mulseq;

  logic        clk = 1'b0;
  logic        reset;
  logic        go_u, go_s;
  logic [31:0] a_u, b_u, a_s, b_s;
  logic [63:0] p_u, p_s;
  logic        done_u, done_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mulseq #(.DATAWIDTH(32), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .go(go_u), .a(a_u), .b(b_u), .p(p_u), .done(done_u)
  );

  mulseq #(.DATAWIDTH(32), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .go(go_s), .a(a_s), .b(b_s), .p(p_s), .done(done_s)
  );

  function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] m;
    if (!sgn) begin
      m = {32'b0, x} * {32'b0, y};
      return m;
    end
    m = {33'b0, x[30:0]} * {33'b0, y[30:0]};
    return {x[31] ^ y[31], m[62:0]};
  endfunction

  // Start one operation and count edges from the start edge until done is seen
  task automatic do_op(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [63:0] prod, output logic d0);
    @(negedge clk);
    if (sgn) begin a_s = x; b_s = y; go_s = 1'b1; end
    else     begin a_u = x; b_u = y; go_u = 1'b1; end
    @(posedge clk); #1;
    go_s = 1'b0; go_u = 1'b0;
    d0  = sgn ? done_s : done_u;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (sgn ? done_s : done_u) break;
    end
    prod = sgn ? p_s : p_u;
  endtask

  task automatic test_reset;
    reset = 1'b1; go_u = 1'b0; go_s = 1'b0;
    a_u = '0; b_u = '0; a_s = '0; b_s = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_u !== 1'b0) begin errors++; $display("FAIL reset_done_u: got %b want 0", done_u); end
    checks++; if (p_u !== 64'h0) begin errors++; $display("FAIL reset_p_u: got %h want 0", p_u); end
    checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done_s: got %b want 0", done_s); end
    checks++; if (p_s !== 64'h0) begin errors++; $display("FAIL reset_p_s: got %h want 0", p_s); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_unsigned_directed;
    logic [31:0] xs [4] = '{32'd3, 32'hFFFF_FFFF, 32'd0, 32'd1};
    logic [31:0] ys [4] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [63:0] ex [4] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFE_0000_0001,
                            64'h0, 64'h0000_0000_8000_0000};
    int lat; logic [63:0] prod; logic d0;
    for (int k = 0; k < 4; k++) begin
      do_op(1'b0, xs[k], ys[k], lat, prod, d0);
      checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL u_done_cleared[%0d]: got %b want 0", k, d0); end
      checks++; if (lat != 32) begin errors++; $display("FAIL u_latency[%0d]: got %0d want 32", k, lat); end
      checks++; if (prod !== ex[k]) begin errors++; $display("FAIL u_product[%0d]: got %h want %h", k, prod, ex[k]); end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (done_u !== 1'b1) begin errors++; $display("FAIL u_done_hold[%0d]: got %b want 1", k, done_u); end
      checks++; if (p_u !== ex[k]) begin errors++; $display("FAIL u_p_hold[%0d]: got %h want %h", k, p_u, ex[k]); end
    end
  endtask

  task automatic test_signed_directed;
    logic [31:0] xs [2] = '{32'h8000_0003, 32'h8000_0007};
    logic [31:0] ys [2] = '{32'h0000_0005, 32'h8000_0002};
    logic [63:0] ex [2] = '{64'h8000_0000_0000_000F, 64'h0000_0000_0000_000E};
    int lat; logic [63:0] prod; logic d0;
    for (int k = 0; k < 2; k++) begin
      do_op(1'b1, xs[k], ys[k], lat, prod, d0);
      checks++; if (lat != 31) begin errors++; $display("FAIL s_latency[%0d]: got %0d want 31", k, lat); end
      checks++; if (prod !== ex[k]) begin errors++; $display("FAIL s_product[%0d]: got %h want %h", k, prod, ex[k]); end
    end
  endtask

  task automatic test_random;
    int lat; logic [63:0] prod, exp_p; logic d0; logic [31:0] x, y;
    for (int k = 0; k < 32; k++) begin
      bit sgn;
      sgn = k[0];
      x = $urandom; y = $urandom;
      if (k % 8 == 6) x[30:0] = '0;
      if (k % 8 == 7) y = 32'hFFFF_FFFF;
      exp_p = ref_mul(sgn, x, y);
      do_op(sgn, x, y, lat, prod, d0);
      checks++; if (lat != (sgn ? 31 : 32)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", k, lat, sgn ? 31 : 32); end
      checks++; if (prod !== exp_p) begin errors++; $display("FAIL rnd_product[%0d]: a=%h b=%h s=%0d got %h want %h", k, x, y, sgn, prod, exp_p); end
    end
  endtask

  task automatic test_isolation;
    int lat;
    @(negedge clk); a_u = 32'd6; b_u = 32'd7; go_u = 1'b1;
    @(posedge clk); #1;
    a_u = $urandom; b_u = $urandom;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done_u) begin go_u = 1'b0; break; end
      a_u = $urandom; b_u = $urandom;
    end
    go_u = 1'b0;
    checks++; if (lat != 32) begin errors++; $display("FAIL iso_latency: got %0d want 32", lat); end
    checks++; if (p_u !== 64'd42) begin errors++; $display("FAIL iso_product: got %h want 42", p_u); end
    @(posedge clk); #1;
    checks++; if (done_u !== 1'b1 || p_u !== 64'd42) begin errors++; $display("FAIL iso_hold: done %b p %h want 1 / 42", done_u, p_u); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk); a_u = 32'd2; b_u = 32'd3; go_u = 1'b1;
    @(posedge clk); #1;
    a_u = 32'd4; b_u = 32'd5;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 31 || cyc == 64) begin
        checks++; if (done_u !== 1'b0) begin errors++; $display("FAIL b2b_early_done@%0d: got %b want 0", cyc, done_u); end
      end
      if (cyc == 32) begin
        checks++; if (done_u !== 1'b1 || p_u !== 64'd6) begin errors++; $display("FAIL b2b_first: done %b p %h want 1 / 6", done_u, p_u); end
      end
      if (cyc == 33) begin
        checks++; if (done_u !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b want 0", done_u); end
      end
      if (cyc == 65) begin
        checks++; if (done_u !== 1'b1 || p_u !== 64'd20) begin errors++; $display("FAIL b2b_second: done %b p %h want 1 / 20", done_u, p_u); end
        break;
      end
    end
    go_u = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midrun;
    int lat; logic [63:0] prod; logic d0;
    // done currently high from the previous op: reset must drop it without a clock
    @(posedge clk); #2;
    reset = 1'b1; #1;
    checks++; if (done_u !== 1'b0) begin errors++; $display("FAIL rst_async_done: got %b want 0", done_u); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); a_u = 32'h0001_E241; b_u = 32'h0001_81CD; go_u = 1'b1;
    @(posedge clk); #1; go_u = 1'b0;
    repeat (10) @(posedge clk);
    #3; reset = 1'b1; #1;
    checks++; if (done_u !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", done_u); end
    checks++; if (p_u !== 64'h0) begin errors++; $display("FAIL rst_mid_p: got %h want 0", p_u); end
    @(negedge clk); reset = 1'b0;
    do_op(1'b0, 32'd9, 32'd9, lat, prod, d0);
    checks++; if (lat != 32) begin errors++; $display("FAIL rst_restart_latency: got %0d want 32", lat); end
    checks++; if (prod !== 64'd81) begin errors++; $display("FAIL rst_restart_product: got %h want 81", prod); end
  endtask

  initial begin
    test_reset();
    test_unsigned_directed();
    test_signed_directed();
    test_random();
    test_isolation();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
